// File: rtl/soc_network_adapter_out_arbiter.sv
// soc_network_adapter_out_arbiter
//   Packet-atomic round-robin arbiter merging CHANNELS flit streams from the
//   network adapter sub-modules onto a single NoC output link. The grant is
//   held for a whole packet, and the output is one registered stage.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_flit/last/valid  per-channel input flit stream (flits packed, ch0 at LSB)
//   in_ready            per-channel accept (combinational)
//   out_flit/last/valid registered output flit stream
//   out_ready           downstream accept
//   grant               one-hot owner of the open packet, zero when idle
//   busy                high while a packet is open
module soc_network_adapter_out_arbiter #(
  parameter int FLIT_WIDTH = 32,
  parameter int CHANNELS   = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [CHANNELS*FLIT_WIDTH-1:0] in_flit,
  input  logic [CHANNELS-1:0]            in_last,
  input  logic [CHANNELS-1:0]            in_valid,
  output logic [CHANNELS-1:0]            in_ready,
  output logic [FLIT_WIDTH-1:0]          out_flit,
  output logic                           out_last,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [CHANNELS-1:0]            grant,
  output logic                           busy
);

  localparam int IDX_W = $clog2(CHANNELS);

  // GAP is the one idle input-side cycle after a last-flit transfer; it keeps
  // the end of one packet and arbitration for the next in separate cycles.
  typedef enum logic [1:0] {IDLE, LOCKED, GAP} state_e;

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        ptr_q, ptr_d;
  logic [IDX_W-1:0]        owner_q, owner_d;
  logic [IDX_W-1:0]        sel, cand;
  logic                    sel_ok, space, xfer, sel_last;
  logic [FLIT_WIDTH-1:0]   sel_flit;
  logic [FLIT_WIDTH-1:0]   out_flit_q, out_flit_d;
  logic                    out_last_q, out_last_d;
  logic                    out_valid_q, out_valid_d;

  assign space = !out_valid_q || out_ready;

  // Channel selection: round-robin scan from ptr+1 while idle, owner while locked.
  always_comb begin
    sel    = owner_q;
    sel_ok = 1'b0;
    cand   = '0;
    case (state_q)
      IDLE: begin
        for (int unsigned k = 0; k < CHANNELS; k++) begin
          cand = IDX_W'((32'(ptr_q) + k + 1) % CHANNELS);
          if (!sel_ok && in_valid[cand]) begin
            sel    = cand;
            sel_ok = 1'b1;
          end
        end
      end
      LOCKED: sel_ok = 1'b1;
      default: sel_ok = 1'b0;
    endcase
  end

  // Data mux only reads the selected channel, so X on others cannot leak.
  always_comb begin
    sel_flit = '0;
    sel_last = 1'b0;
    in_ready = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (sel_ok && IDX_W'(i) == sel) begin
        sel_flit    = in_flit[i*FLIT_WIDTH +: FLIT_WIDTH];
        sel_last    = in_last[i];
        in_ready[i] = space;
      end
    end
  end

  assign xfer = space && sel_ok && in_valid[sel];

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    case (state_q)
      IDLE: begin
        if (xfer) begin
          if (sel_last) begin
            state_d = GAP;
            ptr_d   = sel;
          end else begin
            state_d = LOCKED;
            owner_d = sel;
          end
        end
      end
      LOCKED: begin
        if (xfer && sel_last) begin
          state_d = GAP;
          ptr_d   = owner_q;
        end
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    out_flit_d  = out_flit_q;
    out_last_d  = out_last_q;
    out_valid_d = out_valid_q;
    if (xfer) begin
      out_flit_d  = sel_flit;
      out_last_d  = sel_last;
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= IDX_W'(CHANNELS - 1);
      owner_q     <= '0;
      out_flit_q  <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      out_flit_q  <= out_flit_d;
      out_last_q  <= out_last_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_comb begin
    grant = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      grant[i] = (state_q == LOCKED) && (IDX_W'(i) == owner_q);
    end
  end

  assign busy      = (state_q == LOCKED);
  assign out_flit  = out_flit_q;
  assign out_last  = out_last_q;
  assign out_valid = out_valid_q;

endmodule
